sc_chk: RTL and testbench

SC_CHK -- requirements
Module: sc_chk

---
 rtl/sc_pkg.sv | 21 ++
 rtl/sc_expect.sv | 28 ++
 rtl/sc_chk.sv | 104 ++++++++++
 tb/tb_sc_chk.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the sequence checker: state encoding, default
// terminal value and the values a 3-bit producer can never legally emit.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAIL  = 2'd3
  } sc_state_t;

  localparam int unsigned MAX_VAL_DEF = 5;

  localparam logic [2:0] ILL_6 = 3'd6;
  localparam logic [2:0] ILL_7 = 3'd7;

  function automatic logic is_illegal(input logic [2:0] v);
    return (v == ILL_6) || (v == ILL_7);
  endfunction

endpackage

// File: rtl/sc_expect.sv
// Expected-value counter: clears on reset or load_zero, otherwise counts up
// on inc and saturates at MAX_VAL.
module sc_expect
  import sc_pkg::*;
#(
  parameter int unsigned MAX_VAL = MAX_VAL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_zero,
  input  logic       inc,
  output logic [2:0] expected,
  output logic       at_max
);

  localparam logic [2:0] MAX3 = 3'(MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst || load_zero) begin
      expected <= '0;
    end else if (inc && (expected < MAX3)) begin
      expected <= expected + 3'd1;
    end
  end

  assign at_max = (expected == MAX3);

endmodule

// File: rtl/sc_chk.sv
// Checks a saturating 0..MAX_VAL counter sequence; flags mismatches with a
// one-cycle pulse, a sticky flag and a saturating error count.
module sc_chk
  import sc_pkg::*;
#(
  parameter int unsigned MAX_VAL = MAX_VAL_DEF,
  parameter int unsigned ECNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctr_rst,
  input  logic [2:0]        in,
  output logic              err,
  output logic              err_pulse,
  output logic [ECNT_W-1:0] err_cnt,
  output logic              locked
);

  sc_state_t  state;
  sc_state_t  nxt;
  logic       mismatch;
  logic       exp_inc;
  logic       exp_load_zero;
  logic [2:0] expected;
  logic       at_max;

  sc_expect #(
    .MAX_VAL(MAX_VAL)
  ) u_expect (
    .clk      (clk),
    .rst      (rst),
    .load_zero(exp_load_zero),
    .inc      (exp_inc),
    .expected (expected),
    .at_max   (at_max)
  );

  // Expected is always 0 in SYNC (only reset enters it), so a plain
  // increment there yields the expected=1 the first accepted 0 requires.
  always_comb begin
    nxt           = state;
    mismatch      = 1'b0;
    exp_inc       = 1'b0;
    exp_load_zero = 1'b0;
    case (state)
      ST_SYNC: begin
        if (in == 3'd0) begin
          nxt     = ST_TRACK;
          exp_inc = 1'b1;
        end
      end
      ST_TRACK: begin
        if (is_illegal(in) || (in != expected)) begin
          mismatch = 1'b1;
          nxt      = ST_FAIL;
        end else if (at_max) begin
          nxt = ST_HOLD;
        end else begin
          exp_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (is_illegal(in) || (in != expected)) begin
          mismatch = 1'b1;
          nxt      = ST_FAIL;
        end
      end
      ST_FAIL: begin
        nxt = ST_FAIL;
      end
      default: begin
        nxt = ST_SYNC;
      end
    endcase
    // Counter restart overrides whatever was decided for this sample.
    if (ctr_rst) begin
      nxt           = ST_TRACK;
      mismatch      = 1'b0;
      exp_inc       = 1'b0;
      exp_load_zero = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SYNC;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= nxt;
      err_pulse <= mismatch;
      locked    <= (nxt == ST_TRACK) || (nxt == ST_HOLD);
      if (mismatch) begin
        err <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ECNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_chk.sv
// Bench for sc_chk: directed scenarios plus random traffic, checked every
// cycle against an abstract model of the producer/checker protocol.
module tb_sc_chk;

  localparam int MAXV = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ctr_rst = 1'b0;
  logic [2:0] in_v = 3'd0;

  logic       err8, pulse8, locked8;
  logic [7:0] cnt8;
  logic       err2, pulse2, locked2;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sc_chk #(.MAX_VAL(MAXV), .ECNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .in(in_v),
    .err(err8), .err_pulse(pulse8), .err_cnt(cnt8), .locked(locked8)
  );

  sc_chk #(.MAX_VAL(MAXV), .ECNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ctr_rst(ctr_rst), .in(in_v),
    .err(err2), .err_pulse(pulse2), .err_cnt(cnt2), .locked(locked2)
  );

  // Abstract model: waiting-for-first-zero, dead after a mismatch, otherwise
  // the next value the producer owes us.
  bit m_wait = 1'b1;
  bit m_dead = 1'b0;
  int m_exp = 0;
  int m_pulse = 0, m_err = 0, m_cnt = 0, m_locked = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_wait = 1'b1; m_dead = 1'b0; m_exp = 0;
      m_pulse = 0; m_err = 0; m_cnt = 0; m_locked = 0;
    end else if (ctr_rst) begin
      m_wait = 1'b0; m_dead = 1'b0; m_exp = 0;
      m_pulse = 0; m_locked = 1;
    end else if (m_dead) begin
      m_pulse = 0; m_locked = 0;
    end else if (m_wait) begin
      m_pulse = 0;
      if (int'(in_v) == 0) begin
        m_wait = 1'b0; m_exp = 1; m_locked = 1;
      end else begin
        m_locked = 0;
      end
    end else if (int'(in_v) == m_exp) begin
      m_exp = (m_exp < MAXV) ? m_exp + 1 : MAXV;
      m_pulse = 0; m_locked = 1;
    end else begin
      m_dead = 1'b1; m_pulse = 1; m_err = 1; m_cnt++; m_locked = 0;
    end
  end

  function automatic int sat(input int v, input int cap);
    return (v > cap) ? cap : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("err_pulse8", int'(pulse8), m_pulse);
      chk("err8", int'(err8), m_err);
      chk("err_cnt8", int'(cnt8), sat(m_cnt, 255));
      chk("locked8", int'(locked8), m_locked);
      chk("err_pulse2", int'(pulse2), m_pulse);
      chk("err2", int'(err2), m_err);
      chk("err_cnt2", int'(cnt2), sat(m_cnt, 3));
      chk("locked2", int'(locked2), m_locked);
    end
  end

  // Called at a negedge; the edge in between samples these inputs.
  task automatic drive(input bit r, input bit c, input int v);
    rst = r; ctr_rst = c; in_v = 3'(v);
    @(negedge clk);
  endtask

  int prod_next;
  int seq_a[8] = '{0, 1, 2, 3, 4, 5, 5, 5};

  initial begin
    @(negedge clk);
    drive(1, 0, 0);
    drive(1, 1, 7);
    chk_en = 1'b1;
    chk("rst_err", int'(err8), 0);
    chk("rst_pulse", int'(pulse8), 0);
    chk("rst_cnt", int'(cnt8), 0);
    chk("rst_locked", int'(locked8), 0);

    // Clean ramp into HOLD.
    foreach (seq_a[i]) begin
      drive(0, 0, seq_a[i]);
      if (i == 0) chk("ramp_locked_after_0", int'(locked8), 1);
    end
    chk("ramp_cnt", int'(cnt8), 0);
    chk("ramp_locked", int'(locked8), 1);

    // Restart from HOLD with err still clear.
    drive(0, 1, 5);
    drive(0, 0, 0); drive(0, 0, 1); drive(0, 0, 2);
    chk("hold_restart_err", int'(err8), 0);
    chk("hold_restart_locked", int'(locked8), 1);

    // Skip 2 -> mismatch on 3.
    drive(0, 1, 2);
    drive(0, 0, 0); drive(0, 0, 1); drive(0, 0, 3);
    chk("skip_pulse", int'(pulse8), 1);
    chk("skip_err", int'(err8), 1);
    chk("skip_cnt", int'(cnt8), 1);
    chk("skip_locked", int'(locked8), 0);
    drive(0, 0, 4);
    chk("skip_pulse_drop", int'(pulse8), 0);
    drive(0, 0, 5);
    chk("fail_no_recount", int'(cnt8), 1);

    // Restart with err already set: it must stay set.
    drive(0, 1, 5);
    drive(0, 0, 0); drive(0, 0, 1); drive(0, 0, 2);
    chk("sticky_err", int'(err8), 1);
    chk("sticky_locked", int'(locked8), 1);
    chk("sticky_pulse", int'(pulse8), 0);

    // ctr_rst beats an illegal value in the same sample.
    drive(0, 1, 7);
    chk("ctr_vs_ill_pulse", int'(pulse8), 0);
    drive(0, 0, 0);
    chk("ctr_vs_ill_locked", int'(locked8), 1);
    chk("ctr_vs_ill_cnt", int'(cnt8), 1);

    // rst mid-sequence, then a nonzero is ignored, then 0 locks.
    drive(0, 1, 0);
    drive(0, 0, 0); drive(0, 0, 1); drive(0, 0, 2);
    drive(1, 0, 3);
    chk("midrst_err", int'(err8), 0);
    chk("midrst_cnt", int'(cnt8), 0);
    chk("midrst_locked", int'(locked8), 0);
    drive(0, 0, 4);
    chk("sync_ignore_pulse", int'(pulse8), 0);
    chk("sync_ignore_locked", int'(locked8), 0);
    drive(0, 0, 0);
    chk("sync_lock", int'(locked8), 1);

    // Five episodes against the 2-bit counter: 1,2,3,3,3.
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0);
      drive(0, 0, 3);
      chk("sat_cnt2", int'(cnt2), (k < 3) ? k : 3);
      chk("sat_cnt8", int'(cnt8), k);
    end

    // Random traffic that mostly follows a real producer.
    drive(1, 0, 0);
    prod_next = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, c;
      int v;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : prod_next;
      if (r || c) prod_next = 0;
      else prod_next = (prod_next < MAXV) ? prod_next + 1 : MAXV;
      drive(r, c, v);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
